// File: rtl/regbank_pkg.sv
// Shared code map, slice encodings and slice helpers for the register bank.
// Slice functions are the single source of truth for read extraction and write merging.
package regbank_pkg;

  localparam logic [7:0] CODE_STACK_TOP = 8'h20;
  localparam logic [7:0] CODE_STACK_AMT = 8'h21;
  localparam logic [7:0] CODE_CLK       = 8'h22;
  localparam logic [7:0] CODE_SRC       = 8'h24;
  localparam logic [7:0] CODE_K         = 8'h64;
  localparam logic [7:0] CODE_ESP       = 8'h93;

  // GP codes are 1_ii_00_sss: bit 7 set, bits [4:3] clear, index in [6:5].
  localparam logic       GP_BASE_BIT = 1'b1;
  localparam logic [1:0] GP_PAD      = 2'b00;

  localparam int GP_MAX = 4;
  typedef logic [GP_MAX*32-1:0] gp_vec_t;

  typedef enum logic [2:0] {
    SL_W32  = 3'b000,
    SL_W16  = 3'b001,
    SL_B0   = 3'b010,
    SL_B1   = 3'b011,
    SL_NONE = 3'b100,
    SL_H16  = 3'b101,
    SL_B2   = 3'b110,
    SL_B3   = 3'b111
  } slice_e;

  function automatic logic is_gp_code(input logic [7:0] code);
    return (code[7] == GP_BASE_BIT) && (code[4:3] == GP_PAD) &&
           (slice_e'(code[2:0]) != SL_NONE);
  endfunction

  function automatic logic [31:0] slice_read(input logic [31:0] r, input slice_e sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      SL_W32:  v = r;
      SL_W16:  v = {16'h0, r[15:0]};
      SL_B0:   v = {24'h0, r[7:0]};
      SL_B1:   v = {24'h0, r[15:8]};
      SL_H16:  v = {16'h0, r[31:16]};
      SL_B2:   v = {24'h0, r[23:16]};
      SL_B3:   v = {24'h0, r[31:24]};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] slice_merge(input logic [31:0] old, input logic [31:0] data,
                                              input slice_e sel);
    logic [31:0] v;
    v = old;
    case (sel)
      SL_W32:  v = data;
      SL_W16:  v[15:0]  = data[15:0];
      SL_B0:   v[7:0]   = data[7:0];
      SL_B1:   v[15:8]  = data[7:0];
      SL_H16:  v[31:16] = data[15:0];
      SL_B2:   v[23:16] = data[7:0];
      SL_B3:   v[31:24] = data[7:0];
      default: v = old;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/regbank_ctx_lifo.sv
// Context LIFO holding full GP snapshots; count/flags reset asynchronously, memory does not.
// Simultaneous push and pop is a no-op and raises no error.
module regbank_ctx_lifo #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 128,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             of_q, of_d, uf_q, uf_d;
  logic             full, empty, do_push, do_pop;
  logic [AW-1:0]    wr_addr, rd_addr;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push_i && !pop_i && !full;
  assign do_pop  = pop_i && !push_i && !empty;
  assign wr_addr = cnt_q[AW-1:0];
  assign rd_addr = AW'(cnt_q - CW'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
    // clear first so an error on the same edge still sets the flag
    of_d = clear_i ? 1'b0 : of_q;
    uf_d = clear_i ? 1'b0 : uf_q;
    if (push_i && !pop_i && full)  of_d = 1'b1;
    if (pop_i && !push_i && empty) uf_d = 1'b1;
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
    end
  end

  always_ff @(negedge clk_i) begin
    if (do_push) mem[wr_addr] <= data_i;
  end

  assign data_o      = mem[rd_addr];
  assign count_o     = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = of_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/regbank_ctx.sv
// CPU register bank with sliced GP views, special registers and a hardware context LIFO.
// All state commits on the falling clock edge.
module regbank_ctx
  import regbank_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int RD_PORTS  = 3,
  parameter int CTX_DEPTH = 64,
  parameter int BYPASS    = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           REG_write_back_flag,
  input  logic [7:0]                     REG_write_back_code,
  input  logic [31:0]                    REG_write_back_data,
  input  logic [RD_PORTS*8-1:0]          rd_code,
  output logic [RD_PORTS*32-1:0]         rd_value,
  input  logic [31:0]                    STACK_TOP,
  input  logic [15:0]                    STACK_AMOUNT,
  input  logic [31:0]                    r_k,
  input  logic                           DMA_stack_flag,
  input  logic [15:0]                    DMA_stack_data,
  input  logic                           CALL_FLAG,
  input  logic                           RET_FLAG,
  input  logic                           ctx_clear,
  output logic [NUM_REGS*32-1:0]         r_gp,
  output logic [3:0]                     r_clk,
  output logic                           r_src,
  output logic [15:0]                    r_esp,
  output logic [$clog2(CTX_DEPTH+1)-1:0] ctx_count,
  output logic                           ctx_full,
  output logic                           ctx_empty,
  output logic                           ctx_overflow,
  output logic                           ctx_underflow,
  output logic                           STACK_push_flag,
  output logic [31:0]                    STACK_push_value
);

  logic [NUM_REGS-1:0][31:0] gp_q, gp_d, gp_fwd, gp_rd, gp_base, pop_data;
  logic [3:0]  clk_q, clk_d;
  logic        src_q, src_d;
  logic [15:0] esp_q, esp_d;
  logic        wb_gp, pop_ok;
  logic [1:0]  wb_idx;
  slice_e      wb_sel;

  assign wb_idx = REG_write_back_code[6:5];
  assign wb_sel = slice_e'(REG_write_back_code[2:0]);
  assign wb_gp  = REG_write_back_flag && is_gp_code(REG_write_back_code) &&
                  ({30'd0, wb_idx} < 32'(NUM_REGS));
  assign pop_ok = RET_FLAG && !CALL_FLAG && !ctx_empty;

  // Forwarded view merges the write into live registers; next state merges it on top of a restore.
  always_comb begin
    gp_base = pop_ok ? pop_data : gp_q;
    gp_fwd  = gp_q;
    gp_d    = gp_base;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_gp && (wb_idx == 2'(i))) begin
        gp_fwd[i] = slice_merge(gp_q[i], REG_write_back_data, wb_sel);
        gp_d[i]   = slice_merge(gp_base[i], REG_write_back_data, wb_sel);
      end
    end
  end

  always_comb begin
    clk_d = clk_q;
    src_d = src_q;
    esp_d = DMA_stack_flag ? DMA_stack_data : esp_q;
    if (REG_write_back_flag && (REG_write_back_code == CODE_CLK)) clk_d = REG_write_back_data[3:0];
    if (REG_write_back_flag && (REG_write_back_code == CODE_SRC)) src_d = REG_write_back_data[0];
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      gp_q  <= '0;
      clk_q <= 4'h0;
      src_q <= 1'b0;
      esp_q <= 16'hFFFF;
    end else begin
      gp_q  <= gp_d;
      clk_q <= clk_d;
      src_q <= src_d;
      esp_q <= esp_d;
    end
  end

  regbank_ctx_lifo #(
    .DEPTH (CTX_DEPTH),
    .WIDTH (NUM_REGS*32)
  ) u_lifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (CALL_FLAG),
    .pop_i       (RET_FLAG),
    .clear_i     (ctx_clear),
    .data_i      (gp_q),
    .data_o      (pop_data),
    .count_o     (ctx_count),
    .full_o      (ctx_full),
    .empty_o     (ctx_empty),
    .overflow_o  (ctx_overflow),
    .underflow_o (ctx_underflow)
  );

  assign gp_rd = (BYPASS != 0) ? gp_fwd : gp_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [7:0]  c;
    logic [31:0] v;
    assign c = rd_code[8*p +: 8];
    always_comb begin
      v = '0;
      if (is_gp_code(c)) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (c[6:5] == 2'(i)) v = slice_read(gp_rd[i], slice_e'(c[2:0]));
        end
      end else begin
        case (c)
          CODE_STACK_TOP: v = STACK_TOP;
          CODE_STACK_AMT: v = {16'h0, STACK_AMOUNT};
          CODE_CLK:       v = {28'h0, clk_q};
          CODE_SRC:       v = {31'h0, src_q};
          CODE_K:         v = r_k;
          CODE_ESP:       v = {16'h0, esp_q};
          default:        v = '0;
        endcase
      end
    end
    assign rd_value[32*p +: 32] = v;
  end

  assign STACK_push_flag  = (REG_write_back_code == CODE_STACK_TOP);
  assign STACK_push_value = STACK_push_flag ? REG_write_back_data : 32'h0;

  assign r_gp  = gp_q;
  assign r_clk = clk_q;
  assign r_src = src_q;
  assign r_esp = esp_q;

endmodule

// File: tb/tb_regbank_ctx.sv
// Bench for regbank_ctx: two instances (forwarding on/off) share stimulus; a queue model predicts state.
module tb_regbank_ctx;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [127:0] gp;
    int           cnt;
    logic         ov;
    logic         un;
    logic [15:0]  esp;
    logic [3:0]   clk;
    logic         src;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_flag, dma_flag, call, ret, clr;
  logic [7:0]  wb_code;
  logic [31:0] wb_data, stack_top, r_k;
  logic [23:0] rd_code;
  logic [15:0] stack_amt, dma_data;

  logic [95:0]  rd_value, rd_value_b0;
  logic [127:0] r_gp, r_gp_b0;
  logic [3:0]   r_clk, r_clk_b0;
  logic         r_src, r_src_b0;
  logic [15:0]  r_esp, r_esp_b0;
  logic [CW-1:0] ctx_count, ctx_count_b0;
  logic ctx_full, ctx_empty, ctx_of, ctx_uf, push_flag;
  logic ctx_full_b0, ctx_empty_b0, ctx_of_b0, ctx_uf_b0, push_flag_b0;
  logic [31:0] push_value, push_value_b0;

  int checks = 0;
  int errors = 0;

  logic [31:0]  gp_m [4];
  logic [127:0] ctx_m [$];
  logic         ov_m, un_m, src_m;
  logic [3:0]   clk_m;
  logic [15:0]  esp_m;
  exp_t         sb [$];
  logic [31:0]  rq [$];

  always #5 clock = ~clock;

  regbank_ctx #(.NUM_REGS(4), .RD_PORTS(3), .CTX_DEPTH(DEPTH), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .REG_write_back_flag(wb_flag), .REG_write_back_code(wb_code),
    .REG_write_back_data(wb_data), .rd_code(rd_code), .rd_value(rd_value), .STACK_TOP(stack_top),
    .STACK_AMOUNT(stack_amt), .r_k(r_k), .DMA_stack_flag(dma_flag), .DMA_stack_data(dma_data),
    .CALL_FLAG(call), .RET_FLAG(ret), .ctx_clear(clr), .r_gp(r_gp), .r_clk(r_clk), .r_src(r_src),
    .r_esp(r_esp), .ctx_count(ctx_count), .ctx_full(ctx_full), .ctx_empty(ctx_empty),
    .ctx_overflow(ctx_of), .ctx_underflow(ctx_uf), .STACK_push_flag(push_flag),
    .STACK_push_value(push_value));

  regbank_ctx #(.NUM_REGS(4), .RD_PORTS(3), .CTX_DEPTH(DEPTH), .BYPASS(0)) dut_b0 (
    .clock(clock), .reset(reset), .REG_write_back_flag(wb_flag), .REG_write_back_code(wb_code),
    .REG_write_back_data(wb_data), .rd_code(rd_code), .rd_value(rd_value_b0), .STACK_TOP(stack_top),
    .STACK_AMOUNT(stack_amt), .r_k(r_k), .DMA_stack_flag(dma_flag), .DMA_stack_data(dma_data),
    .CALL_FLAG(call), .RET_FLAG(ret), .ctx_clear(clr), .r_gp(r_gp_b0), .r_clk(r_clk_b0),
    .r_src(r_src_b0), .r_esp(r_esp_b0), .ctx_count(ctx_count_b0), .ctx_full(ctx_full_b0),
    .ctx_empty(ctx_empty_b0), .ctx_overflow(ctx_of_b0), .ctx_underflow(ctx_uf_b0),
    .STACK_push_flag(push_flag_b0), .STACK_push_value(push_value_b0));

  function automatic logic [31:0] m_mask(input logic [2:0] sel);
    case (sel)
      3'd0: return 32'hFFFF_FFFF;
      3'd1: return 32'h0000_FFFF;
      3'd2: return 32'h0000_00FF;
      3'd3: return 32'h0000_FF00;
      3'd5: return 32'hFFFF_0000;
      3'd6: return 32'h00FF_0000;
      3'd7: return 32'hFF00_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_lsb(input logic [2:0] sel);
    case (sel)
      3'd3: return 8;
      3'd5, 3'd6: return 16;
      3'd7: return 24;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] r, input logic [2:0] sel);
    return (r & m_mask(sel)) >> m_lsb(sel);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] sel);
    return (old & ~m_mask(sel)) | ((d << m_lsb(sel)) & m_mask(sel));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) gp_m[i] = 32'h0;
    ctx_m.delete();
    ov_m = 1'b0; un_m = 1'b0; clk_m = 4'h0; src_m = 1'b0; esp_m = 16'hFFFF;
  endtask

  task automatic predict();
    exp_t e;
    logic [127:0] snap;
    logic ov_ev, un_ev;
    int idx;
    snap  = {gp_m[3], gp_m[2], gp_m[1], gp_m[0]};
    ov_ev = call && !ret && (ctx_m.size() == DEPTH);
    un_ev = ret && !call && (ctx_m.size() == 0);
    if (clr) begin ov_m = 1'b0; un_m = 1'b0; end
    if (ov_ev) ov_m = 1'b1;
    if (un_ev) un_m = 1'b1;
    if (call && !ret && !ov_ev) ctx_m.push_back(snap);
    if (ret && !call && !un_ev) begin
      snap = ctx_m.pop_back();
      for (int i = 0; i < 4; i++) gp_m[i] = snap[32*i +: 32];
    end
    if (wb_flag && wb_code[7] && (wb_code[4:3] == 2'b00)) begin
      idx = int'(wb_code[6:5]);
      gp_m[idx] = m_merge(gp_m[idx], wb_data, wb_code[2:0]);
    end
    if (wb_flag && (wb_code == 8'h22)) clk_m = wb_data[3:0];
    if (wb_flag && (wb_code == 8'h24)) src_m = wb_data[0];
    if (dma_flag) esp_m = dma_data;
    e.gp = {gp_m[3], gp_m[2], gp_m[1], gp_m[0]};
    e.cnt = ctx_m.size(); e.ov = ov_m; e.un = un_m;
    e.esp = esp_m; e.clk = clk_m; e.src = src_m;
    sb.push_back(e);
  endtask

  task automatic step(input logic wf, input logic [7:0] wc, input logic [31:0] wd,
                      input logic c, input logic r, input logic cl);
    wb_flag = wf; wb_code = wc; wb_data = wd; call = c; ret = r; clr = cl;
    predict();
    #2;
  endtask

  task automatic commit();
    @(negedge clock); #1;
    wb_flag = 1'b0; wb_code = 8'h0; wb_data = 32'h0; call = 1'b0; ret = 1'b0; clr = 1'b0;
    dma_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    checks++; if (r_gp !== 128'h0) begin errors++; $display("FAIL reset_gp got %h want 0", r_gp); end
    checks++; if (r_esp !== 16'hFFFF) begin errors++; $display("FAIL reset_esp got %h want ffff", r_esp); end
    checks++; if (ctx_count !== '0 || ctx_empty !== 1'b1 || ctx_full !== 1'b0) begin
      errors++; $display("FAIL reset_lifo got cnt=%0d e=%b f=%b want 0 1 0", ctx_count, ctx_empty, ctx_full); end
    checks++; if ({ctx_of, ctx_uf, r_clk, r_src} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0", {ctx_of, ctx_uf, r_clk, r_src}); end
    reset = 1'b0;
  endtask

  task automatic test_slices();
    exp_t e;
    logic [7:0] wc, rc;
    logic [31:0] old_rd, new_rd;
    step(1'b1, 8'h80, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b1, 8'h83, 32'h0000_005A, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    checks++; if (r_gp[31:0] !== 32'hDEAD_5AEF) begin errors++; $display("FAIL eax_ah got %h want dead5aef", r_gp[31:0]); end
    rd_code = {8'h88, 8'h84, 8'h81};
    rq.push_back(32'h0000_5AEF);
    step(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    old_rd = rq.pop_front();
    checks++; if (rd_value[31:0] !== old_rd) begin errors++; $display("FAIL read_ax got %h want %h", rd_value[31:0], old_rd); end
    checks++; if (rd_value[95:32] !== 64'h0) begin errors++; $display("FAIL read_unused got %h want 0", rd_value[95:32]); end
    commit(); e = sb.pop_front();
    for (int n = 0; n < 24; n++) begin
      wc = {1'b1, 2'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7))};
      rc = {1'b1, 2'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7))};
      rd_code = {16'h0, rc};
      rq.push_back(m_read(gp_m[int'(rc[6:5])], rc[2:0]));
      step(1'b1, wc, $urandom, 1'b0, 1'b0, 1'b0);
      rq.push_back(m_read(gp_m[int'(rc[6:5])], rc[2:0]));
      old_rd = rq.pop_front(); new_rd = rq.pop_front();
      checks++; if (rd_value_b0[31:0] !== old_rd) begin
        errors++; $display("FAIL rnd_rd_nobyp code=%h got %h want %h", rc, rd_value_b0[31:0], old_rd); end
      checks++; if (rd_value[31:0] !== new_rd) begin
        errors++; $display("FAIL rnd_rd_byp code=%h wr=%h got %h want %h", rc, wc, rd_value[31:0], new_rd); end
      commit(); e = sb.pop_front();
      checks++; if (r_gp !== e.gp || r_gp_b0 !== e.gp) begin
        errors++; $display("FAIL rnd_gp code=%h got %h want %h", wc, r_gp, e.gp); end
    end
    rd_code = 24'h0;
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] old_al, fwd_ax;
    rd_code = {8'h82, 8'h00, 8'h00};
    old_al = m_read(gp_m[0], 3'd2);
    step(1'b1, 8'h82, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_value[95:64] !== 32'h11) begin errors++; $display("FAIL byp_al got %h want 11", rd_value[95:64]); end
    checks++; if (rd_value_b0[95:64] !== old_al) begin errors++; $display("FAIL nobyp_al got %h want %h", rd_value_b0[95:64], old_al); end
    commit(); e = sb.pop_front();
    rd_code = {8'h00, 8'h00, 8'h81};
    step(1'b1, 8'h83, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    fwd_ax = m_read(gp_m[0], 3'd1);
    checks++; if (rd_value[31:0] !== fwd_ax) begin errors++; $display("FAIL byp_overlap got %h want %h", rd_value[31:0], fwd_ax); end
    commit(); e = sb.pop_front();
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL byp_gp got %h want %h", r_gp, e.gp); end
    rd_code = 24'h0;
  endtask

  task automatic test_specials();
    exp_t e;
    stack_top = 32'hCAFE_F00D; stack_amt = 16'h8123; r_k = 32'h1357_9BDF;
    step(1'b1, 8'h22, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    dma_flag = 1'b1; dma_data = 16'hBEEF;
    step(1'b1, 8'h24, 32'h0000_0001, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b1, 8'h93, 32'h0000_1111, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    checks++; if (r_clk !== 4'hA || r_src !== 1'b1 || r_esp !== 16'hBEEF) begin
      errors++; $display("FAIL specials got clk=%h src=%b esp=%h want a 1 beef", r_clk, r_src, r_esp); end
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL esp_code_write got %h want %h", r_gp, e.gp); end
    rd_code = {8'h93, 8'h24, 8'h22};
    #1;
    checks++; if (rd_value !== {32'h0000_BEEF, 32'h1, 32'hA}) begin
      errors++; $display("FAIL rd_special got %h", rd_value); end
    rd_code = {8'h21, 8'h20, 8'h64};
    #1;
    checks++; if (rd_value !== {32'h0000_8123, 32'hCAFE_F00D, 32'h1357_9BDF}) begin
      errors++; $display("FAIL rd_stack_k got %h", rd_value); end
    rd_code = 24'h0;
  endtask

  task automatic test_ctx();
    exp_t e;
    step(1'b1, 8'h80, 32'h1, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b1, 8'hA0, 32'h2, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0); commit(); e = sb.pop_front();
    checks++; if (ctx_count !== CW'(1)) begin errors++; $display("FAIL call_count got %0d want 1", ctx_count); end
    step(1'b1, 8'h80, 32'h9, 1'b0, 1'b0, 1'b0); commit(); e = sb.pop_front();
    checks++; if (r_gp[31:0] !== 32'h9) begin errors++; $display("FAIL call_live got %h want 9", r_gp[31:0]); end
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0); commit(); e = sb.pop_front();
    checks++; if (r_gp[63:0] !== {32'h2, 32'h1} || ctx_count !== '0) begin
      errors++; $display("FAIL ret_restore got %h cnt=%0d want 0000000200000001 0", r_gp[63:0], ctx_count); end
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL ret_gp got %h want %h", r_gp, e.gp); end
  endtask

  task automatic test_full();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'hC0, 32'(k + 100), 1'b1, 1'b0, 1'b0); commit(); e = sb.pop_front();
    end
    checks++; if (ctx_count !== CW'(4) || ctx_full !== 1'b1 || ctx_of !== 1'b1) begin
      errors++; $display("FAIL overflow got cnt=%0d f=%b of=%b want 4 1 1", ctx_count, ctx_full, ctx_of); end
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL overflow_gp got %h want %h", r_gp, e.gp); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0); commit(); e = sb.pop_front();
      checks++; if (r_gp !== e.gp || ctx_count !== CW'(e.cnt)) begin
        errors++; $display("FAIL pop_%0d got %h cnt=%0d want %h %0d", k, r_gp, ctx_count, e.gp, e.cnt); end
    end
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b1); commit(); e = sb.pop_front();
    checks++; if (ctx_uf !== 1'b1 || ctx_of !== 1'b0 || ctx_empty !== 1'b1) begin
      errors++; $display("FAIL underflow_clear got uf=%b of=%b e=%b want 1 0 1", ctx_uf, ctx_of, ctx_empty); end
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL underflow_gp got %h want %h", r_gp, e.gp); end
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1); commit(); e = sb.pop_front();
    checks++; if (ctx_uf !== e.un || ctx_of !== e.ov) begin
      errors++; $display("FAIL clear got uf=%b of=%b want %b %b", ctx_uf, ctx_of, e.un, e.ov); end
  endtask

  task automatic test_same_edge();
    exp_t e;
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b1, 8'hA0, 32'h7, 1'b1, 1'b1, 1'b0); commit(); e = sb.pop_front();
    checks++; if (ctx_count !== CW'(1) || r_gp[63:32] !== 32'h7 || ctx_of !== 1'b0 || ctx_uf !== 1'b0) begin
      errors++; $display("FAIL call_ret got cnt=%0d ebx=%h of=%b uf=%b want 1 7 0 0", ctx_count, r_gp[63:32], ctx_of, ctx_uf); end
    step(1'b1, 8'h80, 32'h3, 1'b0, 1'b1, 1'b0); commit(); e = sb.pop_front();
    checks++; if (r_gp[31:0] !== 32'h3 || ctx_count !== '0) begin
      errors++; $display("FAIL ret_write got eax=%h cnt=%0d want 3 0", r_gp[31:0], ctx_count); end
    checks++; if (r_gp !== e.gp) begin errors++; $display("FAIL ret_write_gp got %h want %h", r_gp, e.gp); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    dma_flag = 1'b1; dma_data = 16'h1234;
    step(1'b1, 8'h22, 32'h5, 1'b1, 1'b0, 1'b0); commit(); e = sb.pop_front();
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0); commit(); e = sb.pop_front();
    checks++; if (ctx_count !== CW'(e.cnt)) begin errors++; $display("FAIL pre_reset_cnt got %0d want %0d", ctx_count, e.cnt); end
    #2; reset = 1'b1; model_reset(); #1;
    checks++; if (r_esp !== 16'hFFFF || ctx_count !== '0 || r_gp !== 128'h0 || r_clk !== 4'h0) begin
      errors++; $display("FAIL mid_reset got esp=%h cnt=%0d gp=%h clk=%h", r_esp, ctx_count, r_gp, r_clk); end
    checks++; if (ctx_of !== 1'b0 || ctx_uf !== 1'b0 || ctx_empty !== 1'b1) begin
      errors++; $display("FAIL mid_reset_flags got of=%b uf=%b e=%b want 0 0 1", ctx_of, ctx_uf, ctx_empty); end
    #1; reset = 1'b0;
    @(negedge clock); #1;
    step(1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0); commit(); e = sb.pop_front();
    checks++; if (ctx_uf !== 1'b1 || r_gp !== e.gp) begin
      errors++; $display("FAIL post_reset_ret got uf=%b gp=%h want 1 %h", ctx_uf, r_gp, e.gp); end
  endtask

  task automatic test_stack_push();
    exp_t e;
    step(1'b1, 8'h20, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    checks++; if (push_flag !== 1'b1 || push_value !== 32'h1234) begin
      errors++; $display("FAIL push got flag=%b val=%h want 1 1234", push_flag, push_value); end
    commit(); e = sb.pop_front();
    checks++; if (r_gp !== e.gp || r_clk !== e.clk || r_src !== e.src) begin
      errors++; $display("FAIL push_nochange got %h want %h", r_gp, e.gp); end
    step(1'b1, 8'h80, 32'h0000_4321, 1'b0, 1'b0, 1'b0);
    checks++; if (push_flag !== 1'b0 || push_value !== 32'h0) begin
      errors++; $display("FAIL nopush got flag=%b val=%h want 0 0", push_flag, push_value); end
    commit(); e = sb.pop_front();
  endtask

  initial begin
    reset = 1'b1; wb_flag = 1'b0; wb_code = 8'h0; wb_data = 32'h0; rd_code = 24'h0;
    stack_top = 32'h0; stack_amt = 16'h0; r_k = 32'h0; dma_flag = 1'b0; dma_data = 16'h0;
    call = 1'b0; ret = 1'b0; clr = 1'b0;
    test_reset();
    test_slices();
    test_bypass();
    test_specials();
    test_ctx();
    test_full();
    test_same_edge();
    test_reset_mid();
    test_stack_push();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
